// File: rtl/axi_cfg_pkg.sv
// Shared types and constants for the AXI4-Lite config-path master.
package axi_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    GAP
  } axi_cfg_state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_EXOKAY = 2'b01;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  localparam logic [31:0] ERR_RD_DATA = 32'hDEADBEEF;
  localparam logic [3:0]  WSTRB_ALL   = 4'hF;

endpackage

// File: rtl/axi_cfg_master_if.sv
// AXI4-Lite bus bundle between the config master and the register interconnect.
interface axi_cfg_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_cfg_timer.sv
// Saturating handshake watchdog for axi_cfg_master (used with AXI_CFG_TIMEOUT_EN).
module axi_cfg_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic axi_clk,
  input  logic axi_resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn)             cnt_q <= '0;
    else if (clear)              cnt_q <= '0;
    else if (enable && !expired) cnt_q <= cnt_q + CW'(1);
  end
endmodule

// File: rtl/axi_cfg_master.sv
// Executes one host config request per FIFO head as a single AXI4-Lite access.
// Optional hung-slave recovery via `define AXI_CFG_TIMEOUT_EN.
module axi_cfg_master
  import axi_cfg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic [31:0]           axi_rdwr_addr,
  input  logic [DATA_WIDTH-1:0] axi_wr_data,
  input  logic                  axi_wr_go,
  input  logic                  axi_rd_go,
  output logic                  axi_wr_done,
  output logic                  axi_rd_done,
  output logic [DATA_WIDTH-1:0] axi_rd_data,
  output logic                  axi_error,
  axi_cfg_master_if.master      m_axi
);

  axi_cfg_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic wr_done_q, wr_done_d, rd_done_q, rd_done_d, error_q, error_d;

`ifdef AXI_CFG_TIMEOUT_EN
  logic tmo_active, tmo_expired;

  assign tmo_active = state_q inside {WR, WR_RESP, RD_ADDR, RD_DATA};

  axi_cfg_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .axi_clk    (axi_clk),
    .axi_resetn (axi_resetn),
    .clear      (!tmo_active),
    .enable     (tmo_active),
    .expired    (tmo_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (axi_wr_go) begin
          addr_d    = axi_rdwr_addr[ADDR_WIDTH-1:0];
          wdata_d   = axi_wr_data;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR;
        end else if (axi_rd_go) begin
          addr_d    = axi_rdwr_addr[ADDR_WIDTH-1:0];
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      WR: begin
        // Each channel retires on its own handshake; leave once both are done.
        awvalid_d = awvalid_q && !m_axi.awready;
        wvalid_d  = wvalid_q && !m_axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi.bvalid) begin
          bready_d  = 1'b0;
          wr_done_d = 1'b1;
          error_d   = (m_axi.bresp != RESP_OKAY);
          state_d   = GAP;
        end
      end
      RD_ADDR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi.rvalid) begin
          rready_d  = 1'b0;
          rd_done_d = 1'b1;
          if (m_axi.rresp == RESP_OKAY) begin
            rd_data_d = m_axi.rdata;
          end else begin
            rd_data_d = ERR_RD_DATA;
            error_d   = 1'b1;
          end
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef AXI_CFG_TIMEOUT_EN
    // Watchdog wins over a coincident handshake so the outcome is always a clean error.
    if (tmo_active && tmo_expired) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      error_d   = 1'b1;
      state_d   = GAP;
      if (state_q inside {WR, WR_RESP}) begin
        wr_done_d = 1'b1;
        rd_done_d = 1'b0;
      end else begin
        wr_done_d = 1'b0;
        rd_done_d = 1'b1;
        rd_data_d = ERR_RD_DATA;
      end
    end
`endif
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      error_q   <= error_d;
    end
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = WSTRB_ALL;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign axi_wr_done = wr_done_q;
  assign axi_rd_done = rd_done_q;
  assign axi_rd_data = rd_data_q;
  assign axi_error   = error_q;

endmodule

// File: tb/tb_axi_cfg_master.sv
// Directed bench for axi_cfg_master: FIFO-head model, delay-programmable AXI slave, scoreboard.
module tb_axi_cfg_master;
  import axi_cfg_pkg::*;

  localparam int unsigned TMO = 16;

  logic        axi_clk = 1'b0;
  logic        axi_resetn;
  logic [31:0] axi_rdwr_addr, axi_wr_data, axi_rd_data;
  logic        axi_wr_go, axi_rd_go, axi_wr_done, axi_rd_done, axi_error;

  axi_cfg_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

  axi_cfg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .axi_clk       (axi_clk),
    .axi_resetn    (axi_resetn),
    .axi_rdwr_addr (axi_rdwr_addr),
    .axi_wr_data   (axi_wr_data),
    .axi_wr_go     (axi_wr_go),
    .axi_rd_go     (axi_rd_go),
    .axi_wr_done   (axi_wr_done),
    .axi_rd_done   (axi_rd_done),
    .axi_rd_data   (axi_rd_data),
    .axi_error     (axi_error),
    .m_axi         (m_axi)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct { bit is_rd; logic [31:0] addr; logic [31:0] data; } req_t;
  typedef struct { bit is_rd; logic [31:0] rdata; bit err; } exp_t;

  req_t req_q[$];
  exp_t sb_q[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  int go_cyc = 0, done_cyc = 0, wr_cyc = 0, rd_cyc = 0, n_wr_done = 0, n_rd_done = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, viol = 0, bready_ph = 0;
  logic [31:0] aw_seen = '0, w_seen = '0, ar_seen = '0;
  logic [3:0]  wstrb_seen = '0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit ar_stuck = 1'b0;
  logic [1:0]  bresp_v = RESP_OKAY, rresp_v = RESP_OKAY;
  logic [31:0] rdata_v = '0;

  always @(posedge axi_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_rd, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_rd, input bit err);
    req_t r;
    exp_t e;
    r.is_rd = is_rd; r.addr = addr; r.data = data;
    e.is_rd = is_rd; e.rdata = exp_rd; e.err = err;
    req_q.push_back(r);
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((req_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
      @(negedge axi_clk);
      n++;
    end
    chk({tag, "_complete"}, 32'((req_q.size() == 0) && (sb_q.size() == 0)), 1);
    repeat (3) @(posedge axi_clk);
    #1;
  endtask

  // FIFO head model + completion monitor
  initial begin
    exp_t e;
    bit   popped;
    bit   prev_bready;
    axi_wr_go = 1'b0; axi_rd_go = 1'b0; axi_rdwr_addr = '0; axi_wr_data = '0;
    prev_bready = 1'b0;
    forever begin
      @(negedge axi_clk);
      popped = 1'b0;
      if (m_axi.bready && !prev_bready) bready_ph++;
      prev_bready = m_axi.bready;
      if (axi_error) chk("err_needs_done", 32'(axi_wr_done | axi_rd_done), 1);
      if (axi_wr_done || axi_rd_done) begin
        done_cyc = cyc;
        if (axi_wr_done) begin n_wr_done++; wr_cyc = cyc; end
        if (axi_rd_done) begin n_rd_done++; rd_cyc = cyc; end
        chk("single_done", 32'(axi_wr_done & axi_rd_done), 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'({axi_wr_done, axi_rd_done}), 0);
        end else begin
          e = sb_q.pop_front();
          chk("done_kind", 32'(axi_rd_done), 32'(e.is_rd));
          chk("error_flag", 32'(axi_error), 32'(e.err));
          if (e.is_rd) chk("rd_data", axi_rd_data, e.rdata);
        end
        if (req_q.size() > 0) begin
          void'(req_q.pop_front());
          popped = 1'b1;
        end
      end
      if (req_q.size() > 0) begin
        if (popped || !(axi_wr_go || axi_rd_go)) go_cyc = cyc;
        axi_wr_go     = !req_q[0].is_rd;
        axi_rd_go     = req_q[0].is_rd;
        axi_rdwr_addr = req_q[0].addr;
        axi_wr_data   = req_q[0].data;
      end else begin
        axi_wr_go = 1'b0;
        axi_rd_go = 1'b0;
      end
    end
  end

  // Slave channels: wait for valid/ready, stall N cycles, then a one-cycle response
  initial begin
    m_axi.awready = 1'b0;
    forever begin
      @(negedge axi_clk);
      if (m_axi.awvalid) begin
        for (int i = 0; i < aw_dly; i++) begin
          @(negedge axi_clk);
          if (axi_resetn && !m_axi.awvalid) viol++;
        end
        m_axi.awready = 1'b1; aw_seen = m_axi.awaddr; aw_hs++;
        @(negedge axi_clk);
        m_axi.awready = 1'b0;
        if (m_axi.awvalid) viol++;
      end
    end
  end

  initial begin
    m_axi.wready = 1'b0;
    forever begin
      @(negedge axi_clk);
      if (m_axi.wvalid) begin
        for (int i = 0; i < w_dly; i++) begin
          @(negedge axi_clk);
          if (axi_resetn && !m_axi.wvalid) viol++;
        end
        m_axi.wready = 1'b1; w_seen = m_axi.wdata; wstrb_seen = m_axi.wstrb; w_hs++;
        @(negedge axi_clk);
        m_axi.wready = 1'b0;
        if (m_axi.wvalid) viol++;
      end
    end
  end

  initial begin
    m_axi.bvalid = 1'b0; m_axi.bresp = RESP_OKAY;
    forever begin
      @(negedge axi_clk);
      if (m_axi.bready) begin
        for (int i = 0; i < b_dly; i++) begin
          @(negedge axi_clk);
          if (axi_resetn && !m_axi.bready) viol++;
        end
        m_axi.bvalid = 1'b1; m_axi.bresp = bresp_v; b_hs++;
        @(negedge axi_clk);
        m_axi.bvalid = 1'b0;
        if (m_axi.bready) viol++;
      end
    end
  end

  initial begin
    m_axi.arready = 1'b0;
    forever begin
      @(negedge axi_clk);
      if (m_axi.arvalid && !ar_stuck) begin
        for (int i = 0; i < ar_dly; i++) begin
          @(negedge axi_clk);
          if (axi_resetn && !m_axi.arvalid) viol++;
        end
        m_axi.arready = 1'b1; ar_seen = m_axi.araddr; ar_hs++;
        @(negedge axi_clk);
        m_axi.arready = 1'b0;
        if (m_axi.arvalid) viol++;
      end
    end
  end

  initial begin
    m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rresp = RESP_OKAY;
    forever begin
      @(negedge axi_clk);
      if (m_axi.rready) begin
        for (int i = 0; i < r_dly; i++) begin
          @(negedge axi_clk);
          if (axi_resetn && !m_axi.rready) viol++;
        end
        m_axi.rvalid = 1'b1; m_axi.rdata = rdata_v; m_axi.rresp = rresp_v; r_hs++;
        @(negedge axi_clk);
        m_axi.rvalid = 1'b0;
        if (m_axi.rready) viol++;
      end
    end
  end

  initial begin
    int n;
    int rd_before;
    axi_resetn = 1'b0;
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_awvalid", 32'(m_axi.awvalid), 0);
    chk("rst_wvalid",  32'(m_axi.wvalid),  0);
    chk("rst_bready",  32'(m_axi.bready),  0);
    chk("rst_arvalid", 32'(m_axi.arvalid), 0);
    chk("rst_rready",  32'(m_axi.rready),  0);
    chk("rst_done",    32'({axi_wr_done, axi_rd_done, axi_error}), 0);
    chk("rst_rd_data", axi_rd_data, 0);
    chk("rst_awaddr",  m_axi.awaddr, 0);
    chk("rst_wdata",   m_axi.wdata, 0);
    axi_resetn = 1'b1;
    @(posedge axi_clk);
    #1;

    // Zero-wait write
    push(1'b0, 32'h7700_0010, 32'hA5A5_0001, '0, 1'b0);
    wait_idle("wr0", 40);
    chk("wr0_awaddr", aw_seen, 32'h7700_0010);
    chk("wr0_wdata",  w_seen, 32'hA5A5_0001);
    chk("wr0_wstrb",  32'(wstrb_seen), 32'hF);
    chk("wr0_hs",     32'({aw_hs[7:0], w_hs[7:0], b_hs[7:0]}), 32'h010101);
    chk("wr0_latency", 32'(done_cyc - go_cyc), 3);
    chk("wr0_ndone",  32'(n_wr_done), 1);

    // Read with slow arready / rvalid
    ar_dly = 4; r_dly = 2; rdata_v = 32'h1234_5678;
    push(1'b1, 32'h7700_0100, '0, 32'h1234_5678, 1'b0);
    wait_idle("rd0", 60);
    chk("rd0_araddr",  ar_seen, 32'h7700_0100);
    chk("rd0_latency", 32'(done_cyc - go_cyc), 9);
    chk("rd0_hs",      32'({ar_hs[7:0], r_hs[7:0]}), 32'h0101);
    chk("rd0_ndone",   32'(n_rd_done), 1);

    // Write channels accepted 3 cycles apart, both orders
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 3; b_dly = 1;
    push(1'b0, 32'h7700_0014, 32'h0000_BEEF, '0, 1'b0);
    wait_idle("wr_wlate", 60);
    chk("wr_wlate_latency", 32'(done_cyc - go_cyc), 7);
    chk("wr_wlate_hs", 32'({aw_hs[7:0], w_hs[7:0], b_hs[7:0]}), 32'h020202);
    chk("wr_wlate_bphase", 32'(bready_ph), 2);
    aw_dly = 3; w_dly = 0; b_dly = 0;
    push(1'b0, 32'h7700_0018, 32'h0000_F00D, '0, 1'b0);
    wait_idle("wr_awlate", 60);
    chk("wr_awlate_latency", 32'(done_cyc - go_cyc), 6);
    chk("wr_awlate_hs", 32'({aw_hs[7:0], w_hs[7:0], b_hs[7:0]}), 32'h030303);
    chk("wr_awlate_bphase", 32'(bready_ph), 3);
    chk("wr_awlate_data", w_seen, 32'h0000_F00D);
    aw_dly = 0;

    // Error responses
    rresp_v = RESP_SLVERR; rdata_v = 32'h5555_AAAA;
    push(1'b1, 32'h7700_0200, '0, ERR_RD_DATA, 1'b1);
    wait_idle("rd_slverr", 40);
    bresp_v = RESP_DECERR;
    push(1'b0, 32'h7700_0204, 32'h0000_0001, '0, 1'b1);
    wait_idle("wr_decerr", 40);
    rresp_v = RESP_OKAY; bresp_v = RESP_OKAY;

    // Back-to-back write then read with go levels held
    rdata_v = 32'hCAFE_0042;
    push(1'b0, 32'h7700_0020, 32'h0000_0002, '0, 1'b0);
    push(1'b1, 32'h7700_0024, '0, 32'hCAFE_0042, 1'b0);
    wait_idle("b2b", 60);
    chk("b2b_aw_hs",   32'(aw_hs), 5);
    chk("b2b_ar_hs",   32'(ar_hs), 3);
    chk("b2b_araddr",  ar_seen, 32'h7700_0024);
    chk("b2b_gap",     32'((rd_cyc - wr_cyc) >= 4), 1);
    chk("b2b_ndone",   32'(n_wr_done + n_rd_done), 8);
    chk("no_handshake_violation", 32'(viol), 0);

    // Reset while waiting for rvalid
    r_dly = 6;
    rd_before = n_rd_done;
    push(1'b1, 32'h7700_0300, '0, 32'h0, 1'b0);
    n = 0;
    while (!m_axi.rready && n < 30) begin
      @(negedge axi_clk);
      n++;
    end
    chk("rst_mid_reached_rdata", 32'(m_axi.rready), 1);
    @(posedge axi_clk);
    #1;
    axi_resetn = 1'b0;
    req_q.delete();
    sb_q.delete();
    #1;
    chk("rst_mid_rready",  32'(m_axi.rready), 0);
    chk("rst_mid_arvalid", 32'(m_axi.arvalid), 0);
    chk("rst_mid_done",    32'({axi_wr_done, axi_rd_done, axi_error}), 0);
    chk("rst_mid_rd_data", axi_rd_data, 0);
    repeat (2) @(posedge axi_clk);
    #1;
    axi_resetn = 1'b1;
    repeat (12) @(posedge axi_clk);
    #1;
    chk("rst_mid_no_done", 32'(n_rd_done), 32'(rd_before));
    r_dly = 0;

`ifdef AXI_CFG_TIMEOUT_EN
    // Hung read-address channel
    ar_stuck = 1'b1;
    push(1'b1, 32'h7700_0400, '0, ERR_RD_DATA, 1'b1);
    wait_idle("tmo", 3 * TMO + 20);
    chk("tmo_arvalid", 32'(m_axi.arvalid), 0);
    chk("tmo_latency_window",
        32'(((done_cyc - go_cyc) >= int'(TMO)) && ((done_cyc - go_cyc) <= int'(TMO) + 3)), 1);
    chk("tmo_ndone", 32'(n_rd_done), 32'(rd_before + 1));
    ar_stuck = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
